ifu_prefetch: RTL and testbench

- Next-generation instruction fetch unit. Issues sequential AXI-lite read requests ahead of decode, with up to MAX_OUTSTANDING reads in flight.
- Buffers returned instructions in a FIFO_DEPTH-entry fetch queue feeding ID over a valid/ready bus.
- A redirect (branch/jump/exception target from ID/WB) flushes the queue. Responses still in flight are discarded without stalling the AXI channel.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_prefetch_if.sv | 25 ++
 rtl/ifu_fifo.sv | 64 ++++++
 rtl/ifu_prefetch.sv | 172 +++++++++++++++++
 tb/tb_ifu_prefetch.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifu_pkg;

    localparam int          IFU_ADDR_W   = 32;
    localparam int          IFU_DATA_W   = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    // Layout of one fetch-queue entry as presented to ID on if_to_id_bus.
    typedef struct packed {
        logic                  fault;
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_REQ  = 1'b1
    } ar_state_e;

endpackage

// File: rtl/ifu_prefetch_if.sv
// AXI-lite read channels (AR + R) between the prefetch unit and memory.
interface ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arready;
    logic                  rvalid;
    logic                  rready;
    logic [1:0]            rresp;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rresp, rdata
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rresp, rdata
    );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous flush; flush
// takes priority over push/pop. Push while full is accepted only with a pop.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers and count, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: AXI-lite reads feeding a fetch queue to ID.
// Optional performance counters are built when IFU_PREFETCH_PERF_EN is defined.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH      = IFU_DATA_W,
    parameter int                    ADDR_WIDTH      = IFU_ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(IFU_RESET_PC),
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter int                    PC_STEP         = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    output logic                           if_to_id_valid,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] if_to_id_bus,
    input  logic                           id_to_if_ready,
    ifu_prefetch_if.master                 axi
`ifdef IFU_PREFETCH_PERF_EN
    ,
    output logic [31:0]                    perf_fetched,
    output logic [31:0]                    perf_dropped,
    output logic [31:0]                    perf_stall
`endif
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int QCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OS_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int DROP_W  = $clog2(MAX_OUTSTANDING + 2);

    ar_state_e             ar_state;
    ar_state_e             ar_state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [DROP_W-1:0]     drop_cnt;
    logic [DROP_W-1:0]     drop_cnt_next;
    logic                  issue;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  credit_ok;
    int                    os_after;

    logic                  fq_push;
    logic                  fq_pop;
    logic                  fq_full;
    logic                  fq_empty;
    logic [QCNT_W-1:0]     fq_count;
    logic [ENTRY_W-1:0]    fq_wdata;

    logic                  pcq_full;
    logic                  pcq_empty;
    logic [OS_W-1:0]       os_count;
    logic [ADDR_WIDTH-1:0] pcq_pc;

    assign axi.arvalid = (ar_state == AR_REQ);
    assign axi.araddr  = ar_addr;
    assign axi.rready  = 1'b1;

    assign ar_fire = axi.arvalid && axi.arready;
    assign r_fire  = axi.rvalid && !pcq_empty;

    // Every accepted request reserves a queue slot, so returning beats never overflow.
    assign credit_ok = !pcq_full && !fq_full &&
                       (int'(os_count) + int'(fq_count) < FIFO_DEPTH);

    assign fq_push  = r_fire && (drop_cnt == '0) && !redirect_valid;
    assign fq_pop   = if_to_id_valid && id_to_if_ready;
    assign fq_wdata = {(axi.rresp != RESP_OKAY), pcq_pc, axi.rdata};
    assign if_to_id_valid = !fq_empty;

    ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fq_push),
        .wdata (fq_wdata),
        .pop   (fq_pop),
        .rdata (if_to_id_bus),
        .count (fq_count),
        .full  (fq_full),
        .empty (fq_empty)
    );

    // Tracks the PC of every accepted read, stale or not; its count is the
    // number of reads in flight.
    ifu_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (ar_fire),
        .wdata (ar_addr),
        .pop   (r_fire),
        .rdata (pcq_pc),
        .count (os_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        ar_state_next = ar_state;
        issue         = 1'b0;
        case (ar_state)
            AR_IDLE: begin
                if (!redirect_valid && credit_ok) begin
                    ar_state_next = AR_REQ;
                    issue         = 1'b1;
                end
            end
            AR_REQ: begin
                if (axi.arready) ar_state_next = AR_IDLE;
            end
            default: ar_state_next = AR_IDLE;
        endcase
    end

    // A redirect recounts everything in flight (plus an unaccepted request) as stale.
    always_comb begin
        drop_cnt_next = drop_cnt;
        os_after      = int'(os_count) + int'(ar_fire) - int'(r_fire);
        if (redirect_valid) begin
            drop_cnt_next = DROP_W'(os_after + int'(axi.arvalid && !axi.arready));
        end else if (r_fire && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - 1'b1;
        end
    end

    // fetch_pc advances at launch; araddr keeps its own copy so a redirect
    // can retarget fetch_pc while an unaccepted request stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_state <= AR_IDLE;
            fetch_pc <= RESET_PC;
            ar_addr  <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            ar_state <= ar_state_next;
            drop_cnt <= drop_cnt_next;
            if (issue) ar_addr <= fetch_pc;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
        end
    end

`ifdef IFU_PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(fq_push);
            perf_dropped <= perf_dropped + 32'(r_fire && !fq_push);
            perf_stall   <= perf_stall + 32'(!credit_ok && fq_full);
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a small in-order AXI-lite read slave.
module tb_ifu_prefetch;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_to_id_valid;
    logic [64:0] if_to_id_bus;
    logic        id_to_if_ready;

    ifu_prefetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    ifu_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus),
        .id_to_if_ready (id_to_if_ready),
        .axi            (axi)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic         ar_block;
    logic         r_en;
    logic         id_ready_knob;
    logic [31:0]  fault_addr;
    logic [31:0]  acc_q[$];
    logic [31:0]  ar_log[$];
    fetch_entry_t deliv[$];
    int           max_os = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    function automatic fetch_entry_t entry_at(input int i);
        if (i < deliv.size()) return deliv[i];
        return '1;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < ar_log.size()) return ar_log[i];
        return '1;
    endfunction

    // One cycle: slave and ID decide their inputs for the coming posedge.
    task automatic step();
        logic [31:0] a;
        @(negedge clk);
        if (r_en && acc_q.size() > 0) begin
            a = acc_q.pop_front();
            axi.rvalid = 1'b1;
            axi.rdata  = inst_of(a);
            axi.rresp  = (a == fault_addr) ? 2'b10 : 2'b00;
        end else begin
            axi.rvalid = 1'b0;
            axi.rdata  = '0;
            axi.rresp  = '0;
        end
        axi.arready = !ar_block;
        if (axi.arvalid && axi.arready) begin
            acc_q.push_back(axi.araddr);
            ar_log.push_back(axi.araddr);
        end
        if (acc_q.size() > max_os) max_os = acc_q.size();
        id_to_if_ready = id_ready_knob;
        if (if_to_id_valid && id_to_if_ready) deliv.push_back(fetch_entry_t'(if_to_id_bus));
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ar_block       = 1'b0;
        r_en           = 1'b1;
        id_ready_knob  = 1'b1;
        fault_addr     = '1;
        acc_q.delete();
        step();
        step();
        acc_q.delete();
        ar_log.delete();
        deliv.delete();
        axi.rvalid = 1'b0;
        check("rst_arvalid", 64'(axi.arvalid), 64'd0);
        check("rst_if_valid", 64'(if_to_id_valid), 64'd0);
        check("rst_rready", 64'(axi.rready), 64'd1);
        rst = 1'b0;
    endtask

    initial begin
        axi.arready    = 1'b0;
        axi.rvalid     = 1'b0;
        axi.rresp      = '0;
        axi.rdata      = '0;
        id_to_if_ready = 1'b0;

        // Sequential fetch, fast slave, ID always ready.
        do_reset();
        repeat (30) step();
        check("t1_araddr0", 64'(log_at(0)), 64'h8000_0000);
        check("t1_araddr1", 64'(log_at(1)), 64'h8000_0004);
        check("t1_araddr2", 64'(log_at(2)), 64'h8000_0008);
        check("t1_pc0", 64'(entry_at(0).pc), 64'h8000_0000);
        check("t1_inst0", 64'(entry_at(0).inst), 64'h25A5_0F0F);
        check("t1_pc1", 64'(entry_at(1).pc), 64'h8000_0004);
        check("t1_inst1", 64'(entry_at(1).inst), 64'h25A5_0F0B);
        check("t1_pc2", 64'(entry_at(2).pc), 64'h8000_0008);
        check("t1_inst2", 64'(entry_at(2).inst), 64'h25A5_0F07);
        check("t1_fault0", 64'(entry_at(0).fault), 64'd0);

        // ID stalled: queue fills to exactly four entries, then issue stops.
        do_reset();
        id_ready_knob = 1'b0;
        repeat (30) step();
        check("t2_ar_count", 64'(ar_log.size()), 64'd4);
        check("t2_arvalid", 64'(axi.arvalid), 64'd0);
        check("t2_if_valid", 64'(if_to_id_valid), 64'd1);
        check("t2_none_taken", 64'(deliv.size()), 64'd0);
        id_ready_knob = 1'b1;
        repeat (40) step();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_pc%0d", i), 64'(entry_at(i).pc), 64'(32'h8000_0000 + 32'(4 * i)));
        end

        // Redirect with two reads in flight: both returning beats are dropped.
        do_reset();
        r_en = 1'b0;
        repeat (8) step();
        check("t3_in_flight", 64'(acc_q.size()), 64'd2);
        check("t3_arvalid_held_off", 64'(axi.arvalid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        step();
        redirect_valid = 1'b0;
        r_en = 1'b1;
        repeat (30) step();
        check("t3_araddr_new", 64'(log_at(2)), 64'h8000_1000);
        check("t3_first_pc", 64'(entry_at(0).pc), 64'h8000_1000);
        check("t3_second_pc", 64'(entry_at(1).pc), 64'h8000_1004);

        // Redirect while an AR is stalled: araddr holds, its response is stale.
        do_reset();
        ar_block = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h8000_1000;
            end
            step();
            redirect_valid = 1'b0;
            check($sformatf("t4_arvalid_hold%0d", i), 64'(axi.arvalid), 64'd1);
            check($sformatf("t4_araddr_hold%0d", i), 64'(axi.araddr), 64'h8000_0000);
        end
        ar_block = 1'b0;
        repeat (30) step();
        check("t4_araddr_old", 64'(log_at(0)), 64'h8000_0000);
        check("t4_araddr_new", 64'(log_at(1)), 64'h8000_1000);
        check("t4_first_pc", 64'(entry_at(0).pc), 64'h8000_1000);
        check("t4_second_pc", 64'(entry_at(1).pc), 64'h8000_1004);

        // Error response marks the entry faulty without stalling fetch.
        do_reset();
        fault_addr = 32'h8000_000C;
        repeat (40) step();
        check("t5_pc3", 64'(entry_at(3).pc), 64'h8000_000C);
        check("t5_fault3", 64'(entry_at(3).fault), 64'd1);
        check("t5_fault2", 64'(entry_at(2).fault), 64'd0);
        check("t5_pc4", 64'(entry_at(4).pc), 64'h8000_0010);
        check("t5_fault4", 64'(entry_at(4).fault), 64'd0);

        // Reset mid-operation with reads in flight and entries queued.
        do_reset();
        id_ready_knob = 1'b0;
        r_en = 1'b0;
        repeat (8) step();
        r_en = 1'b1;
        step();
        step();
        r_en = 1'b0;
        repeat (10) step();
        check("t6_pre_in_flight", 64'(acc_q.size()), 64'd2);
        check("t6_pre_if_valid", 64'(if_to_id_valid), 64'd1);
        rst = 1'b1;
        acc_q.delete();
        axi.rvalid = 1'b0;
        step();
        acc_q.delete();
        ar_log.delete();
        deliv.delete();
        axi.rvalid = 1'b0;
        check("t6_if_valid", 64'(if_to_id_valid), 64'd0);
        check("t6_arvalid", 64'(axi.arvalid), 64'd0);
        rst           = 1'b0;
        id_ready_knob = 1'b1;
        r_en          = 1'b1;
        repeat (20) step();
        check("t6_araddr0", 64'(log_at(0)), 64'h8000_0000);
        check("t6_first_pc", 64'(entry_at(0).pc), 64'h8000_0000);

        check("max_outstanding", 64'(max_os <= 2), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
